// File: rtl/instr_adder_pkg.sv
// Shared types and defaults for the iterative ring-feedback adder.
package instr_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_COUNT_W = 16;

endpackage

// File: rtl/adder_core.sv
// Combinational WIDTH-bit adder with carry-out; kept separate so the adder
// architecture can be replaced without touching the sequencer.
module adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/instr_adder_seq.sv
// Iterative adder: repeats A_eff + B for max(iter,1) cycles, with A bits taken
// from sum feedback where ring_mask is set. INSTR_ADDER_OVF_COUNT_EN adds ovf_count.
module instr_adder_seq
    import instr_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               active,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [WIDTH-1:0]   ring_mask,
    input  logic [COUNT_W-1:0] iter,
    output logic [WIDTH-1:0]   sum_out,
    output logic               carry_out,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] cycles,
`ifdef INSTR_ADDER_OVF_COUNT_EN
    output logic [COUNT_W-1:0] ovf_count,
`endif
    output logic [1:0]         state_dbg_o
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, b_q, mask_q, s_q, sum_q;
    logic               carry_q;
    logic [COUNT_W-1:0] iter_q, cycles_q, cycles_d;
    logic [WIDTH-1:0]   a_eff, add_s;
    logic               add_c;
    logic               launch, run_step, last_add;
    logic [COUNT_W:0]   next_cnt;

    assign launch   = (state_q == IDLE) && active && start;
    assign run_step = (state_q == RUN) && active;
    assign a_eff    = (mask_q & s_q) | (~mask_q & a_q);
    assign next_cnt = {1'b0, cycles_q} + {{COUNT_W{1'b0}}, 1'b1};
    assign last_add = (next_cnt == {1'b0, iter_q});
    assign cycles_d = (&cycles_q) ? cycles_q : next_cnt[COUNT_W-1:0];

    adder_core #(.WIDTH(WIDTH)) u_adder (
        .a (a_eff),
        .b (b_q),
        .s (add_s),
        .c (add_c)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping active aborts RUN/DONE straight to IDLE without a done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (active && start) state_d = RUN;
            RUN: begin
                if (!active)       state_d = IDLE;
                else if (last_add) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        state_dbg_o = state_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            iter_q   <= '0;
            s_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cycles_q <= '0;
        end else if (launch) begin
            a_q      <= a_in;
            b_q      <= b_in;
            mask_q   <= ring_mask;
            iter_q   <= (iter == '0) ? {{(COUNT_W-1){1'b0}}, 1'b1} : iter;
            s_q      <= a_in;
            cycles_q <= '0;
        end else if (run_step) begin
            s_q      <= add_s;
            sum_q    <= add_s;
            carry_q  <= add_c;
            cycles_q <= cycles_d;
        end
    end

    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign cycles    = cycles_q;

`ifdef INSTR_ADDER_OVF_COUNT_EN
    logic [COUNT_W-1:0] ovf_q, ovf_d;

    assign ovf_d = (&ovf_q) ? ovf_q : ovf_q + {{(COUNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf_q <= '0;
        end else if (launch) begin
            ovf_q <= '0;
        end else if (run_step && add_c) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_instr_adder_seq.sv
// Directed bench for instr_adder_seq; ovf_count checks build in when
// INSTR_ADDER_OVF_COUNT_EN is defined.
module tb_instr_adder_seq;
    import instr_adder_pkg::*;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               active, start;
    logic [WIDTH-1:0]   a_in, b_in, ring_mask;
    logic [COUNT_W-1:0] iter;
    logic [WIDTH-1:0]   sum_out;
    logic               carry_out, busy, done;
    logic [COUNT_W-1:0] cycles;
`ifdef INSTR_ADDER_OVF_COUNT_EN
    logic [COUNT_W-1:0] ovf_count;
`endif
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    instr_adder_seq #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .active      (active),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .ring_mask   (ring_mask),
        .iter        (iter),
        .sum_out     (sum_out),
        .carry_out   (carry_out),
        .busy        (busy),
        .done        (done),
        .cycles      (cycles),
`ifdef INSTR_ADDER_OVF_COUNT_EN
        .ovf_count   (ovf_count),
`endif
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one launch; returns one cycle later, in the first RUN cycle.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] mask, input logic [COUNT_W-1:0] it,
                          input logic [WIDTH-1:0] exp_sum);
        a_in      = a;
        b_in      = b;
        ring_mask = mask;
        iter      = it;
        start     = 1'b1;
        exp_q.push_back(exp_sum);
        tick();
        start     = 1'b0;
    endtask

    // k0 is the cycle index (relative to the launch cycle) at entry.
    task automatic wait_done(input string tag, input int k0, input int n,
                             input logic exp_c, input int exp_cycles);
        int k = k0;
        logic [WIDTH-1:0] exp_sum;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check({tag, " done_cycle"}, 64'(k), 64'(n + 1));
        exp_sum = exp_q.pop_front();
        check({tag, " sum"}, 64'(sum_out), 64'(exp_sum));
        check({tag, " carry"}, 64'(carry_out), 64'(exp_c));
        check({tag, " cycles"}, 64'(cycles), 64'(exp_cycles));
        tick();
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " busy_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] drop;
        rst = 1'b1; active = 1'b1; start = 1'b0;
        a_in = '0; b_in = '0; ring_mask = '0; iter = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst sum", 64'(sum_out), 64'(0));
        check("rst carry", 64'(carry_out), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst cycles", 64'(cycles), 64'(0));
        check("rst state", 64'(state_dbg), 64'(IDLE));
`ifdef INSTR_ADDER_OVF_COUNT_EN
        check("rst ovf", 64'(ovf_count), 64'(0));
`endif
        rst = 1'b0;
        tick();

        launch(32'd5, 32'd3, 32'd0, 16'd1, 32'd8);
        check("t036 busy", 64'(busy), 64'(1));
        wait_done("t036", 1, 1, 1'b0, 1);
        tick();
        check("t036 hold_sum", 64'(sum_out), 64'(8));

        launch(32'd0, 32'd1, 32'hFFFF_FFFF, 16'd10, 32'd10);
        wait_done("t037", 1, 10, 1'b0, 10);

        launch(32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF, 16'd8, 32'h10);
        wait_done("t038", 1, 8, 1'b0, 8);
`ifdef INSTR_ADDER_OVF_COUNT_EN
        check("t038 ovf", 64'(ovf_count), 64'(1));
`endif

        launch(32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0, 32'd0);
        wait_done("t039", 1, 1, 1'b1, 1);
`ifdef INSTR_ADDER_OVF_COUNT_EN
        check("t039 ovf", 64'(ovf_count), 64'(1));
`endif

        // Mask 0x3: 0xF -> 0x10 -> 0xD -> 0xE
        launch(32'h0F, 32'd1, 32'h3, 16'd3, 32'hE);
        wait_done("mask", 1, 3, 1'b0, 3);

        launch(32'd100, 32'd7, 32'd0, 16'd5, 32'd107);
        tick();
        a_in  = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("start_in_run", 3, 5, 1'b0, 5);

        launch(32'd1, 32'd1, 32'd0, 16'd1, 32'd2);
        tick();
        check("start_in_done done", 64'(done), 64'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done busy", 64'(busy), 64'(0));
        check("start_in_done state", 64'(state_dbg), 64'(IDLE));
        drop = exp_q.pop_front();
        check("start_in_done sum", 64'(sum_out), 64'(drop));

        active = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("inactive busy", 64'(busy), 64'(0));
        active = 1'b1;

        launch(32'd100, 32'd7, 32'd0, 16'd20, 32'd107);
        repeat (4) tick();
        active = 1'b0;
        tick();
        check("t040 busy", 64'(busy), 64'(0));
        check("t040 cycles", 64'(cycles), 64'(4));
        drop = exp_q.pop_front();
        check("t040 sum", 64'(sum_out), 64'(drop));
        for (int i = 0; i < 3; i++) begin
            check("t040 no_done", 64'(done), 64'(0));
            tick();
        end
        active = 1'b1;

        launch(32'd9, 32'd9, 32'd0, 16'd20, 32'd18);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t041 sum", 64'(sum_out), 64'(0));
        check("t041 carry", 64'(carry_out), 64'(0));
        check("t041 busy", 64'(busy), 64'(0));
        check("t041 done", 64'(done), 64'(0));
        check("t041 cycles", 64'(cycles), 64'(0));
`ifdef INSTR_ADDER_OVF_COUNT_EN
        check("t041 ovf", 64'(ovf_count), 64'(0));
`endif
        drop = exp_q.pop_front();
        tick();
        rst = 1'b0;
        launch(32'd5, 32'd3, 32'd0, 16'd1, 32'd8);
        wait_done("t041 rerun", 1, 1, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
